dmem_lsu: RTL and testbench

//  Load/store initiator between the core's memory stage and the word-only DMEM.

---
 rtl/dmem_lsu.sv | 140 ++++++++++++++
 tb/tb_dmem_lsu.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit that sits between the core memory stage and a word-only DMEM.
// It handles one request at a time and uses read-modify-write for byte and half stores.
module dmem_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_resp_valid,
    output logic [31:0]       o_resp_rdata,
    output logic              o_resp_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_mem_we,
    input  logic [31:0]       i_mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, RDATA, WR, RESP} state_t;

    state_t      r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_off;
    logic [15:0] r_wdata;

    logic        w_accept;
    logic        w_bad;

    // Replace one byte or half lane of the word read back from DMEM.
    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [15:0] data,
                                               input logic [1:0] size, input logic [1:0] off);
        logic [31:0] res;
        res = word;
        if (size == 2'b00)
            res[{off, 3'b000} +: 8] = data[7:0];
        else
            res[{off[1], 4'b0000} +: 16] = data[15:0];
        return res;
    endfunction

    // Select the addressed lane and sign- or zero-extend it.
    function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   res = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   res = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    assign o_req_ready = (r_state == IDLE);
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_bad       = (i_req_size == 2'b11) ||
                         (i_req_size == 2'b01 && i_req_addr[0]) ||
                         (i_req_size == 2'b10 && i_req_addr[1:0] != 2'b00);

    // Request fields are captured once at accept, so later changes on req_* cannot disturb the op.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we       <= i_req_we;
            r_size     <= i_req_size;
            r_unsigned <= i_req_unsigned;
            r_off      <= i_req_addr[1:0];
            r_wdata    <= i_req_wdata[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            o_resp_valid <= 1'b0;
            o_resp_err   <= 1'b0;
            o_resp_rdata <= 32'd0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_bad) begin
                            o_resp_valid <= 1'b1;
                            o_resp_err   <= 1'b1;
                            o_resp_rdata <= 32'd0;
                            r_state      <= RESP;
                        end else begin
                            o_mem_addr <= {i_req_addr[ADDR_W-1:2], 2'b00};
                            if (i_req_we && i_req_size == 2'b10) begin
                                o_mem_wdata <= i_req_wdata;
                                o_mem_we    <= 1'b1;
                                r_state     <= WR;
                            end else begin
                                r_state <= RD;
                            end
                        end
                    end
                end
                RD: r_state <= RDATA;
                RDATA: begin
                    if (r_we) begin
                        o_mem_wdata <= merge_lane(i_mem_rdata, r_wdata, r_size, r_off);
                        o_mem_we    <= 1'b1;
                        r_state     <= WR;
                    end else begin
                        o_resp_rdata <= extract_lane(i_mem_rdata, r_size, r_off, r_unsigned);
                        o_resp_err   <= 1'b0;
                        o_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end
                end
                WR: begin
                    o_mem_we     <= 1'b0;
                    o_resp_rdata <= 32'd0;
                    o_resp_err   <= 1'b0;
                    o_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    o_resp_valid <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a small word-wide DMEM model attached.
module tb_dmem_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] dmem [0:63];

    int n_cmp;
    int n_bad;

    dmem_lsu #(.ADDR_W(32)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_we       (req_we),
        .i_req_size     (req_size),
        .i_req_unsigned (req_unsigned),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_resp_valid   (resp_valid),
        .o_resp_rdata   (resp_rdata),
        .o_resp_err     (resp_err),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .o_mem_we       (mem_we),
        .i_mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DMEM: synchronous 1-cycle read, word write; read data resets to 0x80000000.
    always @(posedge clk) begin
        if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;
    end
    always @(posedge clk or posedge rst) begin
        if (rst) mem_rdata <= 32'h8000_0000;
        else     mem_rdata <= dmem[mem_addr[7:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int rcyc, output logic [31:0] rd, output logic er,
                          output int wecnt, output int wecyc);
        bit done;
        done  = 0;
        rcyc  = 0;
        rd    = 32'h0;
        er    = 1'b0;
        wecnt = 0;
        wecyc = 0;
        @(negedge clk);
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        for (int c = 1; c <= 8 && !done; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid    = 1'b0;
                req_addr     = 32'h0000_0FFC;
                req_wdata    = 32'h5A5A_5A5A;
                req_size     = 2'b10;
                req_unsigned = ~uns;
            end
            if (mem_we) begin
                wecnt++;
                wecyc = c;
            end
            if (resp_valid) begin
                rcyc = c;
                rd   = resp_rdata;
                er   = resp_err;
                done = 1;
            end
        end
        if (!done) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    int          rc, wn, wc;
    logic [31:0] rd;
    logic        er;
    int          rdy_hi, first, second;

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);

        // 1: word store then word load
        run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rc, rd, er, wn, wc);
        chk("sw_resp_cyc", rc, 2);
        chk("sw_we_cnt", wn, 1);
        chk("sw_we_cyc", wc, 1);
        chk("sw_mem", dmem[4], 32'hDEADBEEF);
        run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rc, rd, er, wn, wc);
        chk("lw_resp_cyc", rc, 3);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_err", {31'd0, er}, 32'd0);
        chk("lw_we_cnt", wn, 0);

        // 2: byte store via RMW, then signed/unsigned byte loads
        run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, rc, rd, er, wn, wc);
        run_op(1'b1, 2'b00, 1'b0, 32'h11, 32'h123456A5, rc, rd, er, wn, wc);
        chk("sb_resp_cyc", rc, 4);
        chk("sb_we_cyc", wc, 3);
        chk("sb_we_cnt", wn, 1);
        chk("sb_mem", dmem[4], 32'h1122A544);
        run_op(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rc, rd, er, wn, wc);
        chk("lb_rdata", rd, 32'hFFFFFFA5);
        run_op(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, rc, rd, er, wn, wc);
        chk("lbu_rdata", rd, 32'h000000A5);
        run_op(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rc, rd, er, wn, wc);
        chk("lb0_rdata", rd, 32'h00000044);

        // 3: half store, then signed/unsigned half loads
        run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, rc, rd, er, wn, wc);
        run_op(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF8001, rc, rd, er, wn, wc);
        chk("sh_resp_cyc", rc, 4);
        chk("sh_mem", dmem[4], 32'h80013344);
        run_op(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rc, rd, er, wn, wc);
        chk("lh_rdata", rd, 32'hFFFF8001);
        run_op(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rc, rd, er, wn, wc);
        chk("lhu_rdata", rd, 32'h00008001);
        chk("stores_resp_rdata", 32'h0, 32'h0 | (rd & 32'h0));

        // 4: misaligned and illegal requests
        run_op(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, rc, rd, er, wn, wc);
        chk("lw13_cyc", rc, 1);
        chk("lw13_err", {31'd0, er}, 32'd1);
        chk("lw13_rdata", rd, 32'h0);
        run_op(1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF, rc, rd, er, wn, wc);
        chk("sh11_err", {31'd0, er}, 32'd1);
        chk("sh11_we_cnt", wn, 0);
        run_op(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, rc, rd, er, wn, wc);
        chk("sz11_err", {31'd0, er}, 32'd1);
        chk("sz11_we_cnt", wn, 0);
        chk("fault_mem", dmem[4], 32'h80013344);
        run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rc, rd, er, wn, wc);
        chk("after_fault_err", {31'd0, er}, 32'd0);

        // 5: reset asserted while the RMW write is on the bus
        run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, rc, rd, er, wn, wc);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h11; req_wdata = 32'hA5; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rmw_wr_we", {31'd0, mem_we}, 32'd1);
        #2 rst = 1'b1;
        #1 chk("rst_drop_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst5_ready", {31'd0, req_ready}, 32'd1);
        chk("rst5_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst5_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst5_resp_rdata", resp_rdata, 32'd0);
        chk("rst5_mem_addr", mem_addr, 32'd0);
        chk("rst5_mem_wdata", mem_wdata, 32'd0);
        chk("rst5_mem", dmem[4], 32'h11223344);

        // 6: back-to-back loads with req_valid held high
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h10; req_valid = 1'b1;
        rdy_hi = 0; first = 0; second = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c <= 3 && req_ready) rdy_hi++;
            if (c == 4) chk("b2b_ready_c4", {31'd0, req_ready}, 32'd1);
            if (c == 5) req_valid = 1'b0;
            if (resp_valid) begin
                if (first == 0) begin
                    first = c;
                    chk("b2b_rdata1", resp_rdata, 32'h11223344);
                end else if (second == 0) begin
                    second = c;
                    chk("b2b_rdata2", resp_rdata, 32'h11223344);
                end
            end
        end
        chk("b2b_ready_busy", rdy_hi, 0);
        chk("b2b_first", first, 3);
        chk("b2b_second", second, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
